// File: rtl/aes_pkg.sv
// Shared AES definitions: cipher direction and GF(2^8) S-box arithmetic.
package aes_pkg;

    typedef enum logic {
        CIPH_FWD = 1'b0,
        CIPH_INV = 1'b1
    } ciph_op_e;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = a;
        e    = 8'hFE;
        for (int unsigned i = 0; i < 8; i++) begin
            if (e[i]) begin
                r = gf_mul(r, base);
            end
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    // Forward affine transform applied after inversion.
    function automatic logic [7:0] aff_fwd(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine transform applied before inversion.
    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// Single combinational S-box lane, forward or inverse.
module aes_sbox_lut
    import aes_pkg::*;
(
    input  ciph_op_e   op_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    // Select forward (invert then affine) or inverse (affine then invert).
    always_comb begin
        if (op_i == CIPH_INV) begin
            data_o = gf_inv(aff_inv(data_i));
        end else begin
            data_o = aff_fwd(gf_inv(data_i));
        end
    end

endmodule

// File: rtl/aes_sbox_sched.sv
// Time-shares NumSbox S-box lanes between the state SubBytes path and the
// key-expansion SubWord path, one transaction at a time.
module aes_sbox_sched
    import aes_pkg::*;
#(
    parameter int unsigned NumSbox = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,

    input  logic           st_valid_i,
    output logic           st_ready_o,
    input  ciph_op_e       st_op_i,
    input  logic [127:0]   st_data_i,
    output logic           st_valid_o,
    input  logic           st_ready_i,
    output logic [127:0]   st_data_o,

    input  logic           key_valid_i,
    output logic           key_ready_o,
    input  logic [31:0]    key_data_i,
    output logic           key_valid_o,
    input  logic           key_ready_i,
    output logic [31:0]    key_data_o
);

    if (NumSbox != 1 && NumSbox != 2 && NumSbox != 4) begin : g_bad_numsbox
        $error("aes_sbox_sched: NumSbox must be 1, 2 or 4");
    end

    localparam int unsigned BeatsMax = 16 / NumSbox;
    localparam int unsigned BeatW    = $clog2(BeatsMax);
    localparam logic [BeatW-1:0] StLast  = BeatW'(16 / NumSbox - 1);
    localparam logic [BeatW-1:0] KeyLast = BeatW'(4 / NumSbox - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e             state_q;
    logic               owner_key_q;
    logic               prio_key_q;
    ciph_op_e           op_q;
    logic [127:0]       in_q;
    logic [127:0]       work_q;
    logic [127:0]       st_buf_q;
    logic [31:0]        key_buf_q;
    logic               st_valid_q;
    logic               key_valid_q;
    logic [BeatW-1:0]   beat_q;

    logic               grant_key;
    logic               grant_st;
    logic               contested;
    logic               is_last;
    logic               own_valid;
    logic               own_ready;

    logic [3:0]         lane_idx [NumSbox];
    logic [7:0]         lane_in  [NumSbox];
    logic [7:0]         lane_out [NumSbox];

    // Arbitration and handshake qualifiers derived from the current state.
    always_comb begin
        contested = key_valid_i && st_valid_i;
        grant_key = (state_q == IDLE) && rst_ni && !clear_i && key_valid_i
                    && (!st_valid_i || prio_key_q);
        grant_st  = (state_q == IDLE) && rst_ni && !clear_i && st_valid_i
                    && !grant_key;
        is_last   = beat_q == (owner_key_q ? KeyLast : StLast);
        own_valid = owner_key_q ? key_valid_q : st_valid_q;
        own_ready = owner_key_q ? key_ready_i : st_ready_i;
    end

    assign key_ready_o = grant_key;
    assign st_ready_o  = grant_st;
    assign st_valid_o  = st_valid_q;
    assign key_valid_o = key_valid_q;
    assign st_data_o   = st_buf_q;
    assign key_data_o  = key_buf_q;

    // Byte addressed by each lane for the current beat.
    always_comb begin
        for (int unsigned i = 0; i < NumSbox; i++) begin
            lane_idx[i] = 4'(32'(beat_q) * NumSbox + i);
            lane_in[i]  = in_q[{lane_idx[i], 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < NumSbox; g++) begin : g_lane
        aes_sbox_lut u_lut (
            .op_i   (op_q),
            .data_i (lane_in[g]),
            .data_o (lane_out[g])
        );
    end

    // Transaction FSM with registered result buffers and valid flags.
    // Lanes fill a private work buffer; it is copied to the owner's output
    // buffer on the first DONE cycle, so data_o never shows a partial result
    // and the non-owner's data_o is untouched.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_key_q <= 1'b0;
            prio_key_q  <= 1'b1;
            op_q        <= CIPH_FWD;
            in_q        <= '0;
            work_q      <= '0;
            st_buf_q    <= '0;
            key_buf_q   <= '0;
            st_valid_q  <= 1'b0;
            key_valid_q <= 1'b0;
            beat_q      <= '0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            work_q      <= '0;
            st_buf_q    <= '0;
            key_buf_q   <= '0;
            st_valid_q  <= 1'b0;
            key_valid_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_key) begin
                        owner_key_q <= 1'b1;
                        op_q        <= CIPH_FWD;
                        in_q        <= {96'b0, key_data_i};
                        beat_q      <= '0;
                        state_q     <= BUSY;
                    end else if (grant_st) begin
                        owner_key_q <= 1'b0;
                        op_q        <= st_op_i;
                        in_q        <= st_data_i;
                        beat_q      <= '0;
                        state_q     <= BUSY;
                    end
                    // Priority only moves when both requesters competed.
                    if ((grant_key || grant_st) && contested) begin
                        prio_key_q <= grant_st;
                    end
                end
                BUSY: begin
                    for (int unsigned i = 0; i < NumSbox; i++) begin
                        work_q[{lane_idx[i], 3'b000} +: 8] <= lane_out[i];
                    end
                    if (is_last) begin
                        state_q <= DONE;
                    end else begin
                        beat_q <= beat_q + BeatW'(1);
                    end
                end
                DONE: begin
                    if (!own_valid) begin
                        if (owner_key_q) begin
                            key_buf_q   <= work_q[31:0];
                            key_valid_q <= 1'b1;
                        end else begin
                            st_buf_q    <= work_q;
                            st_valid_q  <= 1'b1;
                        end
                    end else if (own_ready) begin
                        st_valid_q  <= 1'b0;
                        key_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
